// File: rtl/out_port_mp_pkg.sv
`default_nettype none
// ============================================================================
// Package : out_port_mp_pkg
// Brief   : FSM state type and PPC helpers shared by out_port_mp and its timing core.
// Rev     : 1.0
// ============================================================================
package out_port_mp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_HBLANK = 2'd2,
      ST_ACTIVE = 2'd3
   } state_e;

   function automatic bit ppc_legal(input int ppc);
      return (ppc == 1) || (ppc == 2) || (ppc == 4);
   endfunction

   function automatic int ppc_log2(input int ppc);
      return (ppc >= 4) ? 2 : ((ppc >= 2) ? 1 : 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_mp_timing.sv
`default_nettype none
// ============================================================================
// Module : out_port_mp_timing
// Brief  : Frame FSM with beat/line/blank counters and per-frame timing shadows.
// Rev    : 1.0
// ============================================================================
module out_port_mp_timing
   import out_port_mp_pkg::*;
#(
   parameter int PPC   = 1,
   parameter int CSIZE = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic [CSIZE-1:0] hactive_i,
   input  logic [CSIZE-1:0] vactive_i,
   input  logic [CSIZE-1:0] hblank_i,
   input  logic [CSIZE-1:0] vblank_i,
   input  logic             step_i,
   output logic             active_o,
   output logic             first_beat_o,
   output logic             last_beat_o,
   output logic             last_line_o
);

   localparam int               PPC_LOG2 = ppc_log2(PPC);
   localparam logic [CSIZE-1:0] C_ONE    = {{(CSIZE-1){1'b0}}, 1'b1};

   state_e           state_q,  state_d;
   logic [CSIZE-1:0] hlast_q,  hlast_d;
   logic [CSIZE-1:0] vlast_q,  vlast_d;
   logic [CSIZE-1:0] hblank_q, hblank_d;
   logic [CSIZE-1:0] vblank_q, vblank_d;
   logic [CSIZE-1:0] hcnt_q,   hcnt_d;
   logic [CSIZE-1:0] vcnt_q,   vcnt_d;
   logic [CSIZE-1:0] bcnt_q,   bcnt_d;

   logic [CSIZE-1:0] hbeats;
   logic             cfg_ok;
   logic             load_shadow;
   logic             hblank_done;
   logic             vblank_done;

   assign hbeats = hactive_i >> PPC_LOG2;
   assign cfg_ok = (hbeats != '0) && (vactive_i != '0);

   // One extra bit so an all-ones blank length cannot wrap; a zero length still spends one cycle
   assign hblank_done = ({1'b0, bcnt_q} + {1'b0, C_ONE}) >= {1'b0, hblank_q};
   assign vblank_done = ({1'b0, bcnt_q} + {1'b0, C_ONE}) >= {1'b0, vblank_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         hlast_q  <= '0;
         vlast_q  <= '0;
         hblank_q <= '0;
         vblank_q <= '0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         bcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         hlast_q  <= hlast_d;
         vlast_q  <= vlast_d;
         hblank_q <= hblank_d;
         vblank_q <= vblank_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         bcnt_q   <= bcnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hlast_d     = hlast_q;
      vlast_d     = vlast_q;
      hblank_d    = hblank_q;
      vblank_d    = vblank_q;
      hcnt_d      = hcnt_q;
      vcnt_d      = vcnt_q;
      bcnt_d      = bcnt_q;
      load_shadow = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i && cfg_ok) begin
               state_d     = ST_VBLANK;
               load_shadow = 1'b1;
            end
         end
         ST_VBLANK: begin
            if (vblank_done) begin
               state_d = ST_ACTIVE;
               bcnt_d  = '0;
            end else begin
               bcnt_d  = bcnt_q + C_ONE;
            end
         end
         ST_HBLANK: begin
            if (hblank_done) begin
               state_d = ST_ACTIVE;
               bcnt_d  = '0;
               vcnt_d  = vcnt_q + C_ONE;
            end else begin
               bcnt_d  = bcnt_q + C_ONE;
            end
         end
         ST_ACTIVE: begin
            if (step_i) begin
               if (hcnt_q == hlast_q) begin
                  hcnt_d = '0;
                  if (vcnt_q == vlast_q) begin
                     vcnt_d = '0;
                     if (enable_i && cfg_ok) begin
                        state_d     = ST_VBLANK;
                        load_shadow = 1'b1;
                     end else begin
                        state_d     = ST_IDLE;
                     end
                  end else begin
                     state_d = ST_HBLANK;
                  end
               end else begin
                  hcnt_d = hcnt_q + C_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Timing ports are only honoured here, at a frame start
      if (load_shadow) begin
         hlast_d  = hbeats - C_ONE;
         vlast_d  = vactive_i - C_ONE;
         hblank_d = hblank_i;
         vblank_d = vblank_i;
         hcnt_d   = '0;
         vcnt_d   = '0;
         bcnt_d   = '0;
      end
   end

   always_comb begin
      active_o     = (state_q == ST_ACTIVE);
      last_beat_o  = (hcnt_q == hlast_q);
      last_line_o  = (vcnt_q == vlast_q);
      first_beat_o = (hcnt_q == '0) && (vcnt_q == '0);
   end

endmodule
`default_nettype wire

// File: rtl/out_port_mp.sv
`default_nettype none
// ============================================================================
// Module : out_port_mp
// Brief  : Multi-pixel VDMA output port: show-ahead FIFO beats to AXI4-Stream video.
//          Define OUT_PORT_MP_UNDERFLOW_CNT_EN to build the saturating stall counter.
// Rev    : 1.0
// ============================================================================
module out_port_mp
   import out_port_mp_pkg::*;
#(
   parameter int DSIZE = 24,
   parameter int PPC   = 1,
   parameter int CSIZE = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic [CSIZE-1:0]     hactive_i,
   input  logic [CSIZE-1:0]     vactive_i,
   input  logic [CSIZE-1:0]     hblank_i,
   input  logic [CSIZE-1:0]     vblank_i,
   input  logic                 fifo_empty_i,
   input  logic [DSIZE*PPC-1:0] in_data_i,
   output logic                 rd_en_o,
   output logic [DSIZE*PPC-1:0] axi_tdata_o,
   output logic                 axi_tvalid_o,
   input  logic                 axi_tready_i,
   output logic                 axi_tuser_o,
   output logic                 axi_tlast_o,
   output logic                 falign_o,
   output logic                 lalign_o,
   output logic                 ealign_o,
   output logic [CSIZE-1:0]     underflow_cnt_o
);

   if (!ppc_legal(PPC)) begin : g_ppc_illegal
      $error("out_port_mp: PPC must be 1, 2 or 4");
   end

   logic                 active;
   logic                 first_beat;
   logic                 last_beat;
   logic                 last_line;
   logic                 rd_en;

   logic [DSIZE*PPC-1:0] tdata_q,  tdata_d;
   logic                 tvalid_q, tvalid_d;
   logic                 tuser_q,  tuser_d;
   logic                 tlast_q,  tlast_d;

   out_port_mp_timing #(
      .PPC   (PPC),
      .CSIZE (CSIZE)
   ) u_timing (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .enable_i     (enable_i),
      .hactive_i    (hactive_i),
      .vactive_i    (vactive_i),
      .hblank_i     (hblank_i),
      .vblank_i     (vblank_i),
      .step_i       (rd_en),
      .active_o     (active),
      .first_beat_o (first_beat),
      .last_beat_o  (last_beat),
      .last_line_o  (last_line)
   );

   // Pop only when the held beat is gone or leaving, so a stalled beat is never overwritten
   assign rd_en = active & ~fifo_empty_i & (~tvalid_q | axi_tready_i);

   always_comb begin
      tdata_d  = tdata_q;
      tuser_d  = tuser_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      if (rd_en) begin
         tdata_d  = in_data_i;
         tuser_d  = first_beat;
         tlast_d  = last_beat;
         tvalid_d = 1'b1;
      end else if (tvalid_q && axi_tready_i) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
      end
   end

   assign rd_en_o      = rd_en;
   assign axi_tdata_o  = tdata_q;
   assign axi_tvalid_o = tvalid_q;
   assign axi_tuser_o  = tuser_q;
   assign axi_tlast_o  = tlast_q;
   assign falign_o     = rd_en & first_beat;
   assign lalign_o     = rd_en & last_beat;
   assign ealign_o     = rd_en & last_beat & last_line;

`ifdef OUT_PORT_MP_UNDERFLOW_CNT_EN
   logic             stall;
   logic [CSIZE-1:0] ucnt_q, ucnt_d;

   assign stall = active & fifo_empty_i & (~tvalid_q | axi_tready_i);

   always_comb begin
      ucnt_d = ucnt_q;
      if (stall && !(&ucnt_q)) begin
         ucnt_d = ucnt_q + {{(CSIZE-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underflow_cnt_o = ucnt_q;
`else
   assign underflow_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_port_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_out_port_mp
// Brief  : Self-checking bench for out_port_mp (PPC=2) with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_out_port_mp;

   localparam int DSIZE = 24;
   localparam int PPC   = 2;
   localparam int CSIZE = 16;
   localparam int W     = DSIZE * PPC;

   typedef struct packed {
      logic [W-1:0] d;
      logic         u;
      logic         l;
   } beat_t;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic             enable     = 1'b0;
   logic [CSIZE-1:0] hactive    = 16'd8;
   logic [CSIZE-1:0] vactive    = 16'd2;
   logic [CSIZE-1:0] hblank     = 16'd3;
   logic [CSIZE-1:0] vblank     = 16'd5;
   logic             fifo_empty = 1'b0;
   logic [W-1:0]     in_data    = '0;
   logic             tready     = 1'b1;

   logic             rd_en;
   logic [W-1:0]     tdata;
   logic             tvalid;
   logic             tuser;
   logic             tlast;
   logic             falign;
   logic             lalign;
   logic             ealign;
   logic [CSIZE-1:0] ucnt;

   out_port_mp #(
      .DSIZE (DSIZE),
      .PPC   (PPC),
      .CSIZE (CSIZE)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .enable_i        (enable),
      .hactive_i       (hactive),
      .vactive_i       (vactive),
      .hblank_i        (hblank),
      .vblank_i        (vblank),
      .fifo_empty_i    (fifo_empty),
      .in_data_i       (in_data),
      .rd_en_o         (rd_en),
      .axi_tdata_o     (tdata),
      .axi_tvalid_o    (tvalid),
      .axi_tready_i    (tready),
      .axi_tuser_o     (tuser),
      .axi_tlast_o     (tlast),
      .falign_o        (falign),
      .lalign_o        (lalign),
      .ealign_o        (ealign),
      .underflow_cnt_o (ucnt)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    failures = 0;

   // Reference model state
   beat_t q[$];
   int    pop_cyc[$];
   int    cyc = 0;
   int    head = 0;
   int    p = 0;
   int    bpl = 0;
   int    vact = 0;
   int    running = 0;
   int    total_pops = 0;
   int    frames = 0;
   int    last_frame_pops = 0;
   logic [2:0] last_marks = '0;
   bit    prev_hold = 0;
   beat_t prev_beat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [W-1:0] mk(input int h);
      logic [DSIZE-1:0] p0, p1;
      p0 = DSIZE'(h * 2);
      p1 = DSIZE'(h * 2 + 1);
      return {p1, p0};
   endfunction

   // FIFO head: the presented word advances after every pop
   initial begin
      forever begin
         @(posedge clk);
         #1;
         in_data = mk(head);
      end
   end

   // Frame-level model and per-cycle compare
   initial begin : model
      beat_t b;
      int    nb;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            check("reset_outputs",
                  {55'd0, rd_en, tvalid, tuser, tlast, falign, lalign, ealign, |tdata, |ucnt}, 64'd0);
            q.delete();
            running   = 0;
            p         = 0;
            prev_hold = 0;
         end else begin
            if (q.size() != 0) begin
               check("tvalid", {63'd0, tvalid}, 64'd1);
               check("beat", {14'd0, tdata, tuser, tlast}, {14'd0, q[0].d, q[0].u, q[0].l});
            end else begin
               check("tvalid_idle", {63'd0, tvalid}, 64'd0);
            end
            if (prev_hold) begin
               check("hold_stable", {13'd0, tvalid, tdata, tuser, tlast}, {13'd0, 1'b1, prev_beat});
            end
            prev_hold = tvalid && !tready;
            prev_beat = {tdata, tuser, tlast};
            if (tvalid && tready && q.size() != 0) q.delete(0);

            if (rd_en) begin
               check("rd_en_legal", {61'd0, running != 0, fifo_empty, tvalid && !tready}, 64'h4);
               head++;
               total_pops++;
               pop_cyc.push_back(cyc);
               last_marks = {falign, lalign, ealign};
               if (running != 0) begin
                  nb = bpl * vact;
                  check("markers", {61'd0, falign, lalign, ealign},
                        {61'd0, p == 0, (p % bpl) == bpl - 1, p == nb - 1});
                  b.d = in_data;
                  b.u = (p == 0);
                  b.l = ((p % bpl) == bpl - 1);
                  q.push_back(b);
                  if (p == nb - 1) begin
                     last_frame_pops = nb;
                     frames++;
                     p = 0;
                     if (enable && (hactive >> 1) != 0 && vactive != 0) begin
                        bpl  = int'(hactive >> 1);
                        vact = int'(vactive);
                     end else begin
                        running = 0;
                     end
                  end else begin
                     p++;
                  end
               end
            end else begin
               check("markers_idle", {61'd0, falign, lalign, ealign}, 64'd0);
               if (running == 0 && enable && (hactive >> 1) != 0 && vactive != 0) begin
                  bpl     = int'(hactive >> 1);
                  vact    = int'(vactive);
                  p       = 0;
                  running = 1;
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pops(input int target, input int budget, input string name);
      int n = 0;
      while (total_pops < target && n < budget) begin
         step(1);
         n++;
      end
      check(name, {63'd0, total_pops >= target}, 64'd1);
   endtask

   task automatic wait_mid_line(input int budget, input string name);
      int n = 0;
      while (!(running != 0 && bpl > 2 && (p % bpl) == 2) && n < budget) begin
         step(1);
         n++;
      end
      check(name, {63'd0, n < budget}, 64'd1);
   endtask

   task automatic wait_line0_beat1(input int budget, input string name);
      int n = 0;
      while (!(running != 0 && p == 1) && n < budget) begin
         step(1);
         n++;
      end
      check(name, {63'd0, n < budget}, 64'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (running != 0 && n < budget) begin
         step(1);
         n++;
      end
      check(name, {63'd0, running == 0}, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int base;
      int en_cyc;
      int snap;
      int fr;

      step(3);
      rst_n = 1'b1;
      step(2);

      // 1: steady stream, two frames
      base   = total_pops;
      en_cyc = cyc + 1;
      enable = 1'b1;
      wait_pops(base + 16, 300, "t1_timeout");
      check("t1_first_pop_latency", 64'(pop_cyc[base] - en_cyc), 64'd6);
      check("t1_beat_spacing", 64'(pop_cyc[base + 1] - pop_cyc[base]), 64'd1);
      check("t1_hblank_gap", 64'(pop_cyc[base + 4] - pop_cyc[base + 3]), 64'd4);
      check("t1_vblank_gap", 64'(pop_cyc[base + 8] - pop_cyc[base + 7]), 64'd6);
      check("t1_frame_pops", 64'(last_frame_pops), 64'd8);

      // 2: back-pressure mid-line
      wait_mid_line(200, "t2_wait");
      snap   = total_pops;
      tready = 1'b0;
      step(6);
      check("t2_no_pop_while_held", 64'(total_pops - snap), 64'd0);
      tready = 1'b1;
      step(10);

      // 3: FIFO underflow mid-line, counted from a fresh reset
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      wait_mid_line(200, "t3_wait");
      snap       = total_pops;
      fifo_empty = 1'b1;
      step(4);
      fifo_empty = 1'b0;
      check("t3_no_pop_while_empty", 64'(total_pops - snap), 64'd0);
`ifdef OUT_PORT_MP_UNDERFLOW_CNT_EN
      check("t3_underflow_cnt", 64'(ucnt), 64'd4);
`else
      check("t3_underflow_cnt", 64'(ucnt), 64'd0);
`endif

      // 4: enable dropped on line 0
      wait_line0_beat1(200, "t4_wait");
      fr     = frames;
      enable = 1'b0;
      wait_idle(200, "t4_idle_timeout");
      check("t4_frame_pops", 64'(last_frame_pops), 64'd8);
      check("t4_frames_done", 64'(frames - fr), 64'd1);
      snap = total_pops;
      step(30);
      check("t4_idle_no_pops", 64'(total_pops - snap), 64'd0);

      // 5: single-beat frames
      hactive = 16'd2;
      vactive = 16'd1;
      hblank  = 16'd0;
      vblank  = 16'd0;
      base    = total_pops;
      enable  = 1'b1;
      wait_pops(base + 4, 100, "t5_timeout");
      check("t5_frame_spacing", 64'(pop_cyc[base + 2] - pop_cyc[base + 1]), 64'd2);
      check("t5_all_markers", {61'd0, last_marks}, 64'h7);
      enable = 1'b0;
      wait_idle(50, "t5_idle_timeout");

      // 6: asynchronous reset mid-line
      hactive = 16'd8;
      vactive = 16'd2;
      hblank  = 16'd3;
      vblank  = 16'd5;
      enable  = 1'b1;
      wait_mid_line(200, "t6_wait");
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_reset",
            {55'd0, rd_en, tvalid, tuser, tlast, falign, lalign, ealign, |tdata, |ucnt}, 64'd0);
      step(2);
      rst_n = 1'b1;
      base  = total_pops;
      wait_pops(base + 1, 100, "t6_timeout");
      check("t6_first_falign", {63'd0, last_marks[2]}, 64'd1);

      // Randomised traffic, including timing changes mid-frame
      snap = total_pops;
      for (int i = 0; i < 4000; i++) begin
         step(1);
         fifo_empty = ($urandom_range(0, 3) == 0);
         tready     = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         if ($urandom_range(0, 149) == 0) begin
            hactive = 16'($urandom_range(2, 12));
            vactive = 16'($urandom_range(1, 3));
            hblank  = 16'($urandom_range(0, 4));
            vblank  = 16'($urandom_range(0, 4));
         end
      end
      check("rand_progress", {63'd0, (total_pops - snap) > 200}, 64'd1);
      enable     = 1'b0;
      fifo_empty = 1'b0;
      tready     = 1'b1;
      wait_idle(2000, "rand_drain_timeout");
      step(5);
      check("rand_drained", {63'd0, tvalid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
